// File: rtl/video_timing_probe.sv
// Measures totals, active sizes and sync polarities of an hs/vs/de stream; locks on two identical frames.
// Results publish one pclk after the registered vs active sample; input-paced by ce_pix, no backpressure.
module video_timing_probe #(
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 4095
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             ce_pix,
  input  logic             hs,
  input  logic             vs,
  input  logic             de,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  output logic             hs_pol,
  output logic             vs_pol,
  output logic             locked,
  output logic             frame_strobe
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;
  localparam logic [1:0] ST_LOCKED  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef struct packed {
    logic [CNT_W-1:0] htot;
    logic [CNT_W-1:0] hact;
    logic [CNT_W-1:0] vtot;
    logic [CNT_W-1:0] vact;
    logic             hpol;
    logic             vpol;
  } meas_t;

  logic             hs_q, vs_q, de_q, hs_p, vs_p, smp_vld;
  logic             pol_hs, pol_vs;
  logic [CNT_W-1:0] hcnt, line_len, hde, frame_hact, lcnt, vact;
  logic             line_de, have_len, line_err;
  logic [1:0]       state;
  meas_t            ref_m, out_m, pub_m;

  logic             hs_edge, vs_edge, len_bad, match, timeout;
  logic [CNT_W-1:0] cur_len, hde_nxt, hact_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign h_total  = out_m.htot;
  assign h_active = out_m.hact;
  assign v_total  = out_m.vtot;
  assign v_active = out_m.vact;
  assign hs_pol   = out_m.hpol;
  assign vs_pol   = out_m.vpol;

  // Active edge: a change into the level opposite to what sync shows during de.
  always_comb begin
    hs_edge  = smp_vld && (hs_q != hs_p) && (hs_q == pol_hs);
    vs_edge  = smp_vld && (vs_q != vs_p) && (vs_q == pol_vs);
    timeout  = (hcnt >= TIMEOUT_C);
    cur_len  = sat_inc(hcnt);
    hde_nxt  = hs_edge ? CNT_W'(de_q) : (de_q ? sat_inc(hde) : hde);
    hact_nxt = (hde_nxt > frame_hact) ? hde_nxt : frame_hact;
    len_bad  = hs_edge && have_len && (cur_len != line_len);
    pub_m    = '{htot: line_len, hact: frame_hact, vtot: lcnt, vact: vact,
                 hpol: pol_hs, vpol: pol_vs};
    match    = (pub_m == ref_m) && (line_len != '0) && (lcnt != '0) && !line_err;
  end

  // Sample registers; a sample is processed the pclk after it is captured.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      hs_p    <= 1'b0;
      vs_p    <= 1'b0;
      smp_vld <= 1'b0;
    end else begin
      if (ce_pix) begin
        hs_q <= hs;
        vs_q <= vs;
        de_q <= de;
      end
      if (smp_vld) begin
        hs_p <= hs_q;
        vs_p <= vs_q;
      end
      smp_vld <= ce_pix;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      pol_hs       <= 1'b0;
      pol_vs       <= 1'b0;
      hcnt         <= '0;
      line_len     <= '0;
      hde          <= '0;
      frame_hact   <= '0;
      lcnt         <= '0;
      vact         <= '0;
      line_de      <= 1'b0;
      have_len     <= 1'b0;
      line_err     <= 1'b0;
      state        <= ST_SEARCH;
      ref_m        <= '0;
      out_m        <= '0;
      locked       <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      if (timeout) begin
        // Loss of signal: drop everything back to the post-reset picture.
        pol_hs     <= 1'b0;
        pol_vs     <= 1'b0;
        hcnt       <= '0;
        line_len   <= '0;
        hde        <= '0;
        frame_hact <= '0;
        lcnt       <= '0;
        vact       <= '0;
        line_de    <= 1'b0;
        have_len   <= 1'b0;
        line_err   <= 1'b0;
        state      <= ST_SEARCH;
        ref_m      <= '0;
        out_m      <= '0;
        locked     <= 1'b0;
      end else if (smp_vld) begin
        hcnt    <= hs_edge ? '0 : cur_len;
        hde     <= hde_nxt;
        line_de <= hs_edge ? de_q : (line_de | de_q);
        if (hs_edge) line_len <= cur_len;
        if (de_q) begin
          pol_hs <= ~hs_q;
          pol_vs <= ~vs_q;
        end

        if (vs_edge) begin
          // A coincident hs edge, and the line it closes, belong to the new frame.
          frame_hact <= hde_nxt;
          lcnt       <= CNT_W'(hs_edge);
          vact       <= CNT_W'(hs_edge && line_de);
          line_err   <= 1'b0;
          have_len   <= hs_edge;
          case (state)
            ST_SEARCH: state <= ST_MEASURE;
            ST_MEASURE: begin
              out_m        <= pub_m;
              frame_strobe <= 1'b1;
              ref_m        <= pub_m;
              state        <= ST_CHECK;
            end
            ST_CHECK: begin
              out_m        <= pub_m;
              frame_strobe <= 1'b1;
              if (match) begin
                locked <= 1'b1;
                state  <= ST_LOCKED;
              end else begin
                ref_m <= pub_m;
              end
            end
            default: begin
              out_m        <= pub_m;
              frame_strobe <= 1'b1;
              if (!match) begin
                locked <= 1'b0;
                ref_m  <= pub_m;
                state  <= ST_CHECK;
              end
            end
          endcase
        end else begin
          frame_hact <= hact_nxt;
          if (hs_edge) begin
            lcnt     <= sat_inc(lcnt);
            have_len <= 1'b1;
            if (line_de) vact <= sat_inc(vact);
          end
          if (len_bad) line_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_timing_probe.sv
// Bench for video_timing_probe on a compact raster: 40 (or 44) x 14 total, 28 x 8 active.
// Stimulus pushes the expected published frame; a negedge monitor pops it on each frame_strobe.
module tb_video_timing_probe;

  localparam int CNT_W  = 12;
  localparam int H_SYNC = 4;
  localparam int H_ACT0 = 8;
  localparam int H_ACT1 = 36;
  localparam int V_SYNC = 2;
  localparam int V_ACT0 = 4;
  localparam int V_ACT1 = 12;
  localparam int V_TOT  = 14;

  typedef struct packed {
    logic [CNT_W-1:0] ht;
    logic [CNT_W-1:0] ha;
    logic [CNT_W-1:0] vt;
    logic [CNT_W-1:0] va;
    logic             hp;
    logic             vp;
    logic             lk;
  } obs_t;

  logic             pclk = 1'b0;
  logic             rst_n = 1'b1;
  logic             ce_pix = 1'b0;
  logic             hs = 1'b1;
  logic             vs = 1'b1;
  logic             de = 1'b0;
  logic [CNT_W-1:0] h_total, h_active, v_total, v_active;
  logic             hs_pol, vs_pol, locked, frame_strobe;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic half_rate = 1'b0;
  obs_t exp_q[$];
  obs_t zero_o = '0;

  video_timing_probe #(.CNT_W(CNT_W), .TIMEOUT(4095)) dut (
    .pclk(pclk), .rst_n(rst_n), .ce_pix(ce_pix), .hs(hs), .vs(vs), .de(de),
    .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
    .hs_pol(hs_pol), .vs_pol(vs_pol), .locked(locked), .frame_strobe(frame_strobe)
  );

  always #5 pclk = ~pclk;

  function automatic obs_t cur_obs();
    return {h_total, h_active, v_total, v_active, hs_pol, vs_pol, locked};
  endfunction

  function automatic obs_t mk(input int ht, input int ha, input int vt, input int va,
                              input logic hp, input logic vp, input logic lk);
    obs_t o;
    o.ht = CNT_W'(ht);
    o.ha = CNT_W'(ha);
    o.vt = CNT_W'(vt);
    o.va = CNT_W'(va);
    o.hp = hp;
    o.vp = vp;
    o.lk = lk;
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got ht=%0d ha=%0d vt=%0d va=%0d hp=%0b vp=%0b lk=%0b, expected ht=%0d ha=%0d vt=%0d va=%0d hp=%0b vp=%0b lk=%0b",
               name, got.ht, got.ha, got.vt, got.va, got.hp, got.vp, got.lk,
               want.ht, want.ha, want.vt, want.va, want.hp, want.vp, want.lk);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, got, want);
    end
  endtask

  // Scoreboard monitor
  always @(negedge pclk) begin
    if (rst_n && frame_strobe) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: got strobe with ht=%0d vt=%0d lk=%0b, expected none",
                 h_total, v_total, locked);
      end else begin
        check("strobe", cur_obs(), exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic h, input logic v, input logic d);
    @(negedge pclk);
    hs = h;
    vs = v;
    de = d;
    ce_pix = 1'b1;
    if (half_rate) begin
      @(negedge pclk);
      ce_pix = 1'b0;
    end
  endtask

  // Lines start at the hs active edge; vs switches on the same sample.
  task automatic send_lines(input int y0, input int n, input int hlen, input logic inv);
    for (int i = 0; i < n; i++) begin
      int y;
      y = (y0 + i) % V_TOT;
      for (int x = 0; x < hlen; x++) begin
        logic h_act, v_act, d;
        h_act = (x < H_SYNC);
        v_act = (y < V_SYNC);
        d = (x >= H_ACT0) && (x < H_ACT1) && (y >= V_ACT0) && (y < V_ACT1);
        drive(~(h_act ^ inv), ~(v_act ^ inv), d);
      end
    end
  endtask

  task automatic push_lock_seq(input int ht, input logic pol);
    exp_q.push_back(mk(ht, 28, 14, 8, pol, pol, 1'b0));
    exp_q.push_back(mk(ht, 28, 14, 8, pol, pol, 1'b1));
    exp_q.push_back(mk(ht, 28, 14, 8, pol, pol, 1'b1));
  endtask

  task automatic do_reset();
    @(negedge pclk);
    rst_n = 1'b0;
    ce_pix = 1'b0;
    hs = 1'b1;
    vs = 1'b1;
    de = 1'b0;
    repeat (3) @(negedge pclk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge pclk);
    check("reset_outputs", cur_obs(), zero_o);
    check_bit("reset_strobe", frame_strobe, 1'b0);
    rst_n = 1'b1;
    @(negedge pclk);
    check("after_release", cur_obs(), zero_o);

    // Active-low syncs, continuous ce: start in active video, run to the 4th vs edge.
    push_lock_seq(40, 1'b0);
    send_lines(4, 53, 40, 1'b0);

    // Line length changes mid-frame while locked.
    exp_q.push_back(mk(44, 28, 14, 8, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(44, 28, 14, 8, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(44, 28, 14, 8, 1'b0, 1'b0, 1'b1));
    send_lines(1, 5, 40, 1'b0);
    send_lines(6, 8, 44, 1'b0);
    send_lines(0, 28, 44, 1'b0);
    send_lines(0, 1, 44, 1'b0);

    // Signal loss: outputs hold for ~4000 samples, then clear without a strobe.
    repeat (4000) drive(1'b1, 1'b1, 1'b0);
    check("pre_timeout", cur_obs(), mk(44, 28, 14, 8, 1'b0, 1'b0, 1'b1));
    begin
      int k;
      k = 0;
      while (cur_obs() !== zero_o && k < 300) begin
        drive(1'b1, 1'b1, 1'b0);
        k++;
      end
      check("timeout_clear", cur_obs(), zero_o);
    end
    push_lock_seq(40, 1'b0);
    send_lines(4, 53, 40, 1'b0);

    // Active-high syncs.
    do_reset();
    push_lock_seq(40, 1'b1);
    send_lines(4, 53, 40, 1'b1);

    // ce_pix every other pclk.
    do_reset();
    half_rate = 1'b1;
    push_lock_seq(40, 1'b0);
    send_lines(4, 53, 40, 1'b0);
    half_rate = 1'b0;

    // Asynchronous reset mid-frame while locked, then relock.
    do_reset();
    exp_q.push_back(mk(40, 28, 14, 8, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(40, 28, 14, 8, 1'b0, 1'b0, 1'b1));
    send_lines(4, 39, 40, 1'b0);
    send_lines(1, 6, 40, 1'b0);
    check("pre_reset_locked", cur_obs(), mk(40, 28, 14, 8, 1'b0, 1'b0, 1'b1));
    @(negedge pclk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", cur_obs(), zero_o);
    check_bit("async_reset_strobe", frame_strobe, 1'b0);
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;
    push_lock_seq(40, 1'b0);
    send_lines(4, 53, 40, 1'b0);

    repeat (5) @(negedge pclk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL strobes_outstanding: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
